// File: rtl/rgb2ycc_if.sv
// Pixel bus between an RGB source and the rgb2ycc converter.
// The master drives the RGB pixel, and the slave returns the Y/Cb/Cr result.
interface rgb2ycc_if;
   logic              [7:0]  iR;
   logic              [7:0]  iG;
   logic              [7:0]  iB;
   logic                     iValid;
   logic signed       [17:0] oY;
   logic signed       [17:0] oCb;
   logic signed       [17:0] oCr;
   logic                     oValid;

   modport master (output iR, iG, iB, iValid, input  oY, oCb, oCr, oValid);
   modport slave  (input  iR, iG, iB, iValid, output oY, oCb, oCr, oValid);
endinterface

// File: rtl/rgb2ycc.sv
// Three-stage pipelined RGB to Y/Cb/Cr converter with Q1.10 coefficients.
// It produces rounded and clamped Q13.5 outputs and accepts one pixel per cycle.
module rgb2ycc #(
   parameter logic signed [11:0] C_YR = 12'sd306,
   parameter logic signed [11:0] C_YG = 12'sd601,
   parameter logic signed [11:0] C_YB = 12'sd117,
   parameter logic signed [11:0] C_BR = -12'sd173,
   parameter logic signed [11:0] C_BG = -12'sd339,
   parameter logic signed [11:0] C_BB = 12'sd512,
   parameter logic signed [11:0] C_RR = 12'sd512,
   parameter logic signed [11:0] C_RG = -12'sd429,
   parameter logic signed [11:0] C_RB = -12'sd83
) (
   input  logic     clk,
   input  logic     reset,
   rgb2ycc_if.slave pix
);
   localparam int unsigned PixW  = 8;
   localparam int unsigned CoefW = 12;
   localparam int unsigned ProdW = 21;
   localparam int unsigned SumW  = 23;
   localparam int unsigned OutW  = 18;

   localparam logic signed [SumW-1:0] YMin = '0;
   localparam logic signed [SumW-1:0] YMax = 23'sd8160;
   localparam logic signed [SumW-1:0] CMin = -23'sd4080;
   localparam logic signed [SumW-1:0] CMax = 23'sd4080;

   // Unsigned pixel times signed coefficient; the zero-extension keeps 255 positive.
   function automatic logic signed [ProdW-1:0] mul(input logic [PixW-1:0] px,
                                                   input logic signed [CoefW-1:0] c);
      return ProdW'($signed({1'b0, px}) * c);
   endfunction

   // Round half up from Q.10 to Q.5, then saturate to [lo, hi].
   function automatic logic signed [OutW-1:0] rndClamp(input logic signed [SumW-1:0] s,
                                                       input logic signed [SumW-1:0] lo,
                                                       input logic signed [SumW-1:0] hi);
      logic signed [SumW-1:0] r;
      r = (s + SumW'(16)) >>> 5;
      if (r < lo)      r = lo;
      else if (r > hi) r = hi;
      return OutW'(r);
   endfunction

   logic signed [ProdW-1:0] prodC [9];
   logic signed [ProdW-1:0] prodQ [9];
   logic signed [SumW-1:0]  sumC  [3];
   logic signed [SumW-1:0]  sumQ  [3];
   logic                    v1;
   logic                    v2;

   always_comb begin
      prodC[0] = mul(pix.iR, C_YR);
      prodC[1] = mul(pix.iG, C_YG);
      prodC[2] = mul(pix.iB, C_YB);
      prodC[3] = mul(pix.iR, C_BR);
      prodC[4] = mul(pix.iG, C_BG);
      prodC[5] = mul(pix.iB, C_BB);
      prodC[6] = mul(pix.iR, C_RR);
      prodC[7] = mul(pix.iG, C_RG);
      prodC[8] = mul(pix.iB, C_RB);
   end

   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         sumC[ch] = SumW'(prodQ[3*ch]) + SumW'(prodQ[3*ch+1]) + SumW'(prodQ[3*ch+2]);
      end
   end

   // Stage 1: product registers. They load only on a valid pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++) prodQ[i] <= '0;
         v1 <= 1'b0;
      end else begin
         if (pix.iValid) begin
            for (int i = 0; i < 9; i++) prodQ[i] <= prodC[i];
         end
         v1 <= pix.iValid;
      end
   end

   // Stage 2: per-channel sums.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < 3; ch++) sumQ[ch] <= '0;
         v2 <= 1'b0;
      end else begin
         if (v1) begin
            for (int ch = 0; ch < 3; ch++) sumQ[ch] <= sumC[ch];
         end
         v2 <= v1;
      end
   end

   // Stage 3: round and clamp into the output registers. These hold between valid pixels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix.oY     <= '0;
         pix.oCb    <= '0;
         pix.oCr    <= '0;
         pix.oValid <= 1'b0;
      end else begin
         if (v2) begin
            pix.oY  <= rndClamp(sumQ[0], YMin, YMax);
            pix.oCb <= rndClamp(sumQ[1], CMin, CMax);
            pix.oCr <= rndClamp(sumQ[2], CMin, CMax);
         end
         pix.oValid <= v2;
      end
   end
endmodule

// File: tb/tb_rgb2ycc.sv
// Scoreboard bench for rgb2ycc. It drives a default instance and two saturating instances from the same pixel stream.
// The monitor pops expected results in order and also checks latency, gaps, output hold and reset.
module tb_rgb2ycc;
   typedef struct packed {
      logic signed [17:0] y;
      logic signed [17:0] cb;
      logic signed [17:0] cr;
   } ycc_t;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   rgb2ycc_if bus0 ();
   rgb2ycc_if bus1 ();
   rgb2ycc_if bus2 ();

   assign bus1.iR = bus0.iR;  assign bus1.iG = bus0.iG;
   assign bus1.iB = bus0.iB;  assign bus1.iValid = bus0.iValid;
   assign bus2.iR = bus0.iR;  assign bus2.iG = bus0.iG;
   assign bus2.iB = bus0.iB;  assign bus2.iValid = bus0.iValid;

   rgb2ycc dut0 (.clk(clk), .reset(reset), .pix(bus0));
   rgb2ycc #(.C_YR(12'sd2047)) dutSatY (.clk(clk), .reset(reset), .pix(bus1));
   rgb2ycc #(.C_BB(12'sd2047)) dutSatB (.clk(clk), .reset(reset), .pix(bus2));

   int cf0 [9] = '{306, 601, 117, -173, -339, 512, 512, -429, -83};
   int cf1 [9] = '{2047, 601, 117, -173, -339, 512, 512, -429, -83};
   int cf2 [9] = '{306, 601, 117, -173, -339, 2047, 512, -429, -83};

   ycc_t expQ [3][$];
   ycc_t lastExp [3];
   logic [2:0] hist;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic ycc_t mk(input int y, input int cb, input int cr);
      ycc_t t;
      t.y = 18'(y); t.cb = 18'(cb); t.cr = 18'(cr);
      return t;
   endfunction

   // Reference arithmetic: floor((sum + 16) / 32) computed in real, then clamped.
   function automatic int refCh(input int s, input int lo, input int hi);
      int v;
      v = int'($floor(real'(s + 16) / 32.0));
      if (v < lo) v = lo;
      if (v > hi) v = hi;
      return v;
   endfunction

   function automatic ycc_t model(input int r, input int g, input int b, input int cf [9]);
      return mk(refCh(r*cf[0] + g*cf[1] + b*cf[2], 0, 8160),
                refCh(r*cf[3] + g*cf[4] + b*cf[5], -4080, 4080),
                refCh(r*cf[6] + g*cf[7] + b*cf[8], -4080, 4080));
   endfunction

   // Expected oValid is iValid delayed by three sampling edges. The history is cleared by reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) hist <= '0;
      else        hist <= {hist[1:0], bus0.iValid};
   end

   task automatic chk(input int idx, input logic v, input ycc_t act);
      ycc_t e;
      if (!reset) begin
         checks++;
         if (v !== 1'b0 || act !== '0) begin
            errors++;
            $display("FAIL inst%0d reset: got v=%0b y=%0d cb=%0d cr=%0d want all 0",
                     idx, v, act.y, act.cb, act.cr);
         end
         expQ[idx].delete();
         lastExp[idx] = '0;
         return;
      end
      checks++;
      if (v !== hist[2]) begin
         errors++;
         $display("FAIL inst%0d valid timing: got %0b want %0b", idx, v, hist[2]);
      end
      if (v === 1'b1) begin
         checks++;
         if (expQ[idx].size() == 0) begin
            errors++;
            $display("FAIL inst%0d unexpected output: got y=%0d, want no output", idx, act.y);
         end else begin
            e = expQ[idx].pop_front();
            lastExp[idx] = e;
            if (act !== e) begin
               errors++;
               $display("FAIL inst%0d data: got y=%0d cb=%0d cr=%0d want y=%0d cb=%0d cr=%0d",
                        idx, act.y, act.cb, act.cr, e.y, e.cb, e.cr);
            end
         end
      end else begin
         checks++;
         if (act !== lastExp[idx]) begin
            errors++;
            $display("FAIL inst%0d hold: got y=%0d cb=%0d cr=%0d want y=%0d cb=%0d cr=%0d",
                     idx, act.y, act.cb, act.cr, lastExp[idx].y, lastExp[idx].cb, lastExp[idx].cr);
         end
      end
   endtask

   // Monitor samples 2 time units after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         chk(0, bus0.oValid, mk(bus0.oY, bus0.oCb, bus0.oCr));
         chk(1, bus1.oValid, mk(bus1.oY, bus1.oCb, bus1.oCr));
         chk(2, bus2.oValid, mk(bus2.oY, bus2.oCb, bus2.oCr));
      end
   end

   task automatic issue(input int r, input int g, input int b, input ycc_t e0, input ycc_t e1, input ycc_t e2);
      @(negedge clk);
      bus0.iR = 8'(r); bus0.iG = 8'(g); bus0.iB = 8'(b); bus0.iValid = 1'b1;
      if (reset) begin
         expQ[0].push_back(e0);
         expQ[1].push_back(e1);
         expQ[2].push_back(e2);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus0.iR = 8'($urandom); bus0.iG = 8'($urandom); bus0.iB = 8'($urandom);
         bus0.iValid = 1'b0;
      end
   endtask

   initial begin
      ycc_t z, white, red, blue;
      int   vCount;
      z     = mk(0, 0, 0);
      white = mk(8160, 0, 0);
      red   = mk(2438, -1379, 4080);
      blue  = mk(932, 4080, -661);

      reset = 1'b0;
      bus0.iR = '0; bus0.iG = '0; bus0.iB = '0; bus0.iValid = 1'b0;
      for (int i = 0; i < 6; i++) issue($urandom_range(0, 255), $urandom_range(0, 255),
                                        $urandom_range(0, 255), z, z, z);
      @(negedge clk);
      bus0.iValid = 1'b0;
      reset = 1'b1;
      idle(1);

      issue(0, 0, 0, z, z, z);
      idle(4);
      issue(255, 255, 255, white, white, mk(8160, 4080, 0));
      issue(255, 0, 0, red, mk(8160, -1379, 4080), red);
      idle(4);
      for (int i = 0; i < 4; i++) issue(0, 0, 255, blue, blue, blue);
      idle(2);
      issue(0, 0, 255, blue, blue, blue);
      idle(5);

      // Reset arrives between the second and third edges of the first pixel.
      issue(255, 0, 0, red, mk(8160, -1379, 4080), red);
      issue(255, 255, 255, white, white, mk(8160, 4080, 0));
      @(negedge clk);
      bus0.iR = 8'd0; bus0.iG = 8'd0; bus0.iB = 8'd255; bus0.iValid = 1'b1;
      reset = 1'b0;
      #1;
      checks++;
      if (bus0.oValid !== 1'b0 || bus0.oY !== '0 || bus0.oCb !== '0 || bus0.oCr !== '0) begin
         errors++;
         $display("FAIL async reset: got v=%0b y=%0d cb=%0d cr=%0d want all 0",
                  bus0.oValid, bus0.oY, bus0.oCb, bus0.oCr);
      end
      idle(2);
      reset = 1'b1;
      vCount = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #3;
         if (bus0.oValid === 1'b1) vCount++;
         @(negedge clk);
         bus0.iValid = 1'b0;
      end
      checks++;
      if (vCount != 0) begin
         errors++;
         $display("FAIL post-reset quiet: got %0d valid outputs want 0", vCount);
      end

      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            int r, g, b;
            r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
            issue(r, g, b, model(r, g, b, cf0), model(r, g, b, cf1), model(r, g, b, cf2));
         end else begin
            idle(1);
         end
      end
      idle(6);

      for (int k = 0; k < 3; k++) begin
         checks++;
         if (expQ[k].size() != 0) begin
            errors++;
            $display("FAIL inst%0d drain: got %0d pending want 0", k, expQ[k].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rgb2ycc.md
# rgb2ycc

Pipelined colour-space converter from 8-bit unsigned RGB pixels to signed 18-bit fixed-point Y/Cb/Cr, using BT.601 coefficients by default. It sits directly upstream of the gamma stage and drives its `iY`/`iCb`/`iCr`/`iValid` inputs. The block has no backpressure: one pixel may be accepted every cycle, and output order matches input order.

## Interface
Parameters: signed 12-bit Q1.10 coefficients, overridable per instance.
- `C_YR` = 306, `C_YG` = 601, `C_YB` = 117: Y row.
- `C_BR` = -173, `C_BG` = -339, `C_BB` = 512: Cb row.
- `C_RR` = 512, `C_RG` = -429, `C_RB` = -83: Cr row.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-low. Low forces all state to zero immediately.
- `iR`, `iG`, `iB`  in  8 each  unsigned pixel components.
- `iValid`  in  1  pixel qualifier.
- `oY`, `oCb`, `oCr`  out  18 each  signed two's-complement Q13.5 (bit 17 sign, bits 16:5 integer, bits 4:0 fraction).
- `oValid`  out  1  output qualifier.

## Operation
- **Stage 1 (multiply):** form nine products, each 8-bit unsigned × 12-bit signed giving a 21-bit signed result. The pixel is zero-extended before multiplying. Register the products only when `iValid` = 1; otherwise hold them. `v1 <= iValid`.
- **Stage 2 (accumulate):** per channel, sum three products into a 23-bit signed value with Q.10 fraction. No overflow is possible at this width. Load only when `v1` = 1. `v2 <= v1`.
- **Stage 3 (round/clamp):**
  - Add 16 (round half up), then arithmetic-shift right by 5 to reach Q.5.
  - Clamp Y to [0, 8160] (0 to 255.0).
  - Clamp Cb and Cr to [-4080, 4080] (±127.5).
  - Sign-extend or truncate to 18 bits after the clamp.
  - Load the output registers only when `v2` = 1. `oValid <= v2`.
- **Output hold:** outputs keep the last valid result while `oValid` = 0.
- **Reset:** while `reset` = 0, all of the following are 0: `oY`, `oCb`, `oCr`, `oValid`, `v1`, `v2`, and all product and sum registers. Effect is asynchronous; there is no wait for a clock edge.
- **Reset mid-stream:** in-flight pixels are discarded. After `reset` rises, no `oValid` pulse appears until a new `iValid` has traversed all three stages.

## Timing
- **Latency:** 3 register stages. A pixel sampled with `iValid` = 1 at edge t appears on the outputs, with `oValid` = 1, immediately after edge t+2.
- **Throughput:** 1 pixel per cycle. Back-to-back `iValid` produces back-to-back `oValid` with the same pattern; gaps are preserved exactly.
- **Outputs:** all are registered. There is no combinational path from any input to any output.
- **Reset release:** must be synchronous to `clk` at system level. The block adds no synchroniser. The first edge after release samples `iValid` normally.

## Test plan
- **Reset:** hold `reset` = 0 while driving random RGB with `iValid` = 1 → all outputs stay 0. Release, then drive R=G=B=0 once → one cycle of `oValid` after edge t+2 with Y = Cb = Cr = 0.
- **White and red:**
  - R=G=B=255 → Y = 8160 (0x01FE0), Cb = 0, Cr = 0.
  - Then R=255, G=0, B=0 → Y = 2438, Cb = -1379 (0x3FA9D), Cr = 4080 (0x00FF0).
- **Blue plus streaming:** R=0, G=0, B=255 → Y = 932, Cb = 4080, Cr = -661 (0x3FD6B). Send it in 4 consecutive cycles, then a 2-cycle gap, then 1 more → `oValid` pattern 1111001 starting 2 edges after the first input. Outputs hold the blue result during the gap.
- **Saturation:** instance with `C_YR` = 2047 and R=255, G=B=0 (unclamped Y = 16312) → Y clamps to 8160. Instance with `C_BB` = 2047 and B=255 → Cb clamps to 4080.
- **Reset mid-stream:**
  - Drive 3 valid pixels, then pull `reset` low between edges t+1 and t+2 of the first pixel → outputs go to 0 at once.
  - After release with `iValid` = 0, `oValid` stays 0 for at least 5 cycles.
- **Random soak:** 10,000 random pixels with random `iValid` → every `oValid` output matches a reference model of the Q1.10 arithmetic (round and clamp as specified) bit-exactly, in input order.
